// File: rtl/fifo_mii_tx.sv
// fifo_mii_tx: drains payload bytes from an 8-bit synchronous FIFO and sends
// preamble, SFD, payload, zero padding, CRC-32 FCS and the inter-frame gap
// onto a 100 Mb/s MII transmit port, one nibble per clock, low nibble first.
module fifo_mii_tx #(
   parameter int PREAMBLE_BYTES = 7,
   parameter int MIN_FRAME      = 60,
   parameter int IFG_BYTES      = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [10:0] tx_len,
   output logic        busy,
   output logic        fifo_rd,
   input  logic [7:0]  fifo_dout,
   input  logic        fifo_empty,
   output logic [3:0]  mii_txd,
   output logic        mii_tx_en,
   output logic        mii_tx_er,
   output logic        tx_done,
   output logic        tx_underrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_SFD   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_PAD   = 3'd4;
   localparam logic [2:0] S_FCS   = 3'd5;
   localparam logic [2:0] S_ABORT = 3'd6;
   localparam logic [2:0] S_IFG   = 3'd7;

   localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
   localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
   localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;

   // One byte through the reflected CRC-32, LSB first as it goes on the wire.
   function automatic logic [31:0] crc8_step(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

   // FCS nibble idx (0 = first on the wire) of the complemented CRC register.
   function automatic logic [3:0] fcs_nib(input logic [31:0] crc, input logic [2:0] idx);
      logic [31:0] s;
      s = crc >> {idx, 2'b00};
      return ~s[3:0];
   endfunction

   // State registers describe the cycle currently on the wire.
   logic [2:0]  state_q, state_d;
   logic        phase_q, phase_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] len_q, len_d;
   logic [31:0] crc_q, crc_d;
   logic [3:0]  hi_q, hi_d;
   logic [3:0]  txd_q, txd_d;
   logic        en_q, en_d;
   logic        er_q, er_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        urun_q, urun_d;
   logic        urun_pend_q, urun_pend_d;

   logic [10:0] cnt_inc;
   logic        more_payload;
   logic        prefetch;

   assign cnt_inc      = cnt_q + 11'd1;
   assign more_payload = (cnt_inc < len_q);
   // Prefetch happens in phase 0 of the byte preceding each payload byte.
   assign prefetch     = (state_q == S_SFD  && !phase_q) ||
                         (state_q == S_DATA && !phase_q && more_payload);
   // Gated by rst so a reset landing on a prefetch cycle consumes nothing.
   assign fifo_rd      = prefetch & ~fifo_empty & ~rst;

   assign busy        = busy_q;
   assign mii_txd     = txd_q;
   assign mii_tx_en   = en_q;
   assign mii_tx_er   = er_q;
   assign tx_done     = done_q;
   assign tx_underrun = urun_q;

   // Next-state and next-output computation for the frame sequencer.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      crc_d       = crc_q;
      hi_d        = hi_q;
      txd_d       = txd_q;
      en_d        = en_q;
      er_d        = er_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      urun_d      = 1'b0;
      urun_pend_d = prefetch & fifo_empty;

      case (state_q)
         S_IDLE: begin
            if (tx_start && tx_len != 11'd0) begin
               state_d = S_PRE;
               phase_d = 1'b0;
               cnt_d   = 11'd0;
               len_d   = tx_len;
               txd_d   = 4'h5;
               en_d    = 1'b1;
               er_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_PRE: begin
            phase_d = ~phase_q;
            txd_d   = 4'h5;
            if (phase_q) begin
               if (cnt_q == PRE_LAST) begin
                  state_d = S_SFD;
                  cnt_d   = 11'd0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_SFD: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               txd_d   = 4'hD;
               crc_d   = 32'hFFFFFFFF;
            end else begin
               phase_d = 1'b0;
               cnt_d   = 11'd0;
               if (urun_pend_q) begin
                  state_d = S_ABORT;
                  txd_d   = 4'h0;
                  er_d    = 1'b1;
                  urun_d  = 1'b1;
               end else begin
                  state_d = S_DATA;
                  txd_d   = fifo_dout[3:0];
                  hi_d    = fifo_dout[7:4];
                  crc_d   = crc8_step(crc_q, fifo_dout);
               end
            end
         end
         S_DATA: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               txd_d   = hi_q;
            end else begin
               phase_d = 1'b0;
               if (more_payload) begin
                  cnt_d = cnt_inc;
                  if (urun_pend_q) begin
                     state_d = S_ABORT;
                     txd_d   = 4'h0;
                     er_d    = 1'b1;
                     urun_d  = 1'b1;
                  end else begin
                     txd_d = fifo_dout[3:0];
                     hi_d  = fifo_dout[7:4];
                     crc_d = crc8_step(crc_q, fifo_dout);
                  end
               end else if (len_q < MIN_LEN) begin
                  state_d = S_PAD;
                  cnt_d   = cnt_inc;
                  txd_d   = 4'h0;
                  crc_d   = crc8_step(crc_q, 8'h00);
               end else begin
                  state_d = S_FCS;
                  cnt_d   = 11'd0;
                  txd_d   = fcs_nib(crc_q, 3'd0);
               end
            end
         end
         S_PAD: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               txd_d   = 4'h0;
            end else begin
               phase_d = 1'b0;
               if (cnt_inc < MIN_LEN) begin
                  cnt_d = cnt_inc;
                  txd_d = 4'h0;
                  crc_d = crc8_step(crc_q, 8'h00);
               end else begin
                  state_d = S_FCS;
                  cnt_d   = 11'd0;
                  txd_d   = fcs_nib(crc_q, 3'd0);
               end
            end
         end
         S_FCS: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               txd_d   = fcs_nib(crc_q, {cnt_q[1:0], 1'b1});
            end else begin
               phase_d = 1'b0;
               if (cnt_q[1:0] == 2'd3) begin
                  state_d = S_IFG;
                  cnt_d   = 11'd0;
                  txd_d   = 4'h0;
                  en_d    = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
                  txd_d = fcs_nib(crc_q, {cnt_inc[1:0], 1'b0});
               end
            end
         end
         S_ABORT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               state_d = S_IFG;
               cnt_d   = 11'd0;
               txd_d   = 4'h0;
               en_d    = 1'b0;
               er_d    = 1'b0;
            end
         end
         S_IFG: begin
            phase_d = ~phase_q;
            if (!phase_q) begin
               // Raise tx_done so it coincides with the final IFG cycle.
               if (cnt_q == IFG_LAST) done_d = 1'b1;
            end else begin
               if (cnt_q == IFG_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = 11'd0;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Register state and all MII-facing outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         cnt_q       <= 11'd0;
         len_q       <= 11'd0;
         crc_q       <= 32'd0;
         hi_q        <= 4'd0;
         txd_q       <= 4'd0;
         en_q        <= 1'b0;
         er_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         urun_q      <= 1'b0;
         urun_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         crc_q       <= crc_d;
         hi_q        <= hi_d;
         txd_q       <= txd_d;
         en_q        <= en_d;
         er_q        <= er_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         urun_q      <= urun_d;
         urun_pend_q <= urun_pend_d;
      end
   end

endmodule

// File: tb/tb_fifo_mii_tx.sv
// tb_fifo_mii_tx: directed frames through two instances (no padding / default
// padding) fed from a shared behavioural FIFO, one line printed per frame.
module tb_fifo_mii_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start;
   logic [10:0] len_in;
   logic        sel;          // 0 = dut_a (MIN_FRAME=0), 1 = dut_b (defaults)

   logic       busy_a, rd_a, en_a, er_a, done_a, urun_a, empty_a;
   logic [3:0] txd_a;
   logic [7:0] dout_a;
   logic       busy_b, rd_b, en_b, er_b, done_b, urun_b, empty_b;
   logic [3:0] txd_b;
   logic [7:0] dout_b;

   fifo_mii_tx #(.PREAMBLE_BYTES(7), .MIN_FRAME(0), .IFG_BYTES(12)) dut_a (
      .clk(clk), .rst(rst), .tx_start(start & ~sel), .tx_len(len_in),
      .busy(busy_a), .fifo_rd(rd_a), .fifo_dout(dout_a), .fifo_empty(empty_a),
      .mii_txd(txd_a), .mii_tx_en(en_a), .mii_tx_er(er_a),
      .tx_done(done_a), .tx_underrun(urun_a));

   fifo_mii_tx dut_b (
      .clk(clk), .rst(rst), .tx_start(start & sel), .tx_len(len_in),
      .busy(busy_b), .fifo_rd(rd_b), .fifo_dout(dout_b), .fifo_empty(empty_b),
      .mii_txd(txd_b), .mii_tx_en(en_b), .mii_tx_er(er_b),
      .tx_done(done_b), .tx_underrun(urun_b));

   // Observed view of whichever instance is under test.
   logic       o_busy, o_rd, o_en, o_er, o_done, o_urun;
   logic [3:0] o_txd;
   assign o_busy = sel ? busy_b : busy_a;
   assign o_rd   = sel ? rd_b   : rd_a;
   assign o_en   = sel ? en_b   : en_a;
   assign o_er   = sel ? er_b   : er_a;
   assign o_done = sel ? done_b : done_a;
   assign o_urun = sel ? urun_b : urun_a;
   assign o_txd  = sel ? txd_b  : txd_a;

   // Behavioural FIFO: data valid the cycle after a read.
   logic [7:0]  mem [0:2047];
   logic [10:0] rd_n, wr_n;
   logic        fifo_clr;
   assign empty_a = sel ? 1'b1 : (rd_n >= wr_n);
   assign empty_b = sel ? (rd_n >= wr_n) : 1'b1;

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_n <= 11'd0;
      end else if (o_rd) begin
         if (sel) dout_b <= mem[rd_n];
         else     dout_a <= mem[rd_n];
         rd_n <= rd_n + 11'd1;
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Capture results of the most recent frame.
   int first_en, last_en, en_cnt, rd_cnt, first_rd, er_cnt, first_er;
   int urun_cnt, urun_at, done_at, busy_k0, idle_before, n_nib;
   int post_en, post_busy, post_txd, post_er;
   int nib [0:4095];

   task automatic fifo_reset();
      fifo_clr = 1'b1;
      @(posedge clk);
      #1 fifo_clr = 1'b0;
   endtask

   function automatic logic [31:0] ref_crc(input int len, input int minf);
      logic [31:0] c;
      int          n;
      c = 32'hFFFFFFFF;
      n = (len > minf) ? len : minf;
      for (int i = 0; i < n; i++) begin
         logic [7:0] b;
         b = (i < len) ? mem[i[10:0]] : 8'h00;
         for (int j = 0; j < 8; j++) begin
            if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
         end
      end
      return c;
   endfunction

   task automatic run_frame(input logic [10:0] len, input int poke_at,
                            input int rst_at, input int budget);
      @(negedge clk);
      idle_before = int'(o_busy);
      start  = 1'b1;
      len_in = len;
      @(posedge clk);
      #1 start = 1'b0;
      first_en = -1; last_en = -1; en_cnt = 0; rd_cnt = 0; first_rd = -1;
      er_cnt = 0; first_er = -1; urun_cnt = 0; urun_at = -1; done_at = -1;
      busy_k0 = 0; n_nib = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (k == poke_at) begin
            start  = 1'b1;
            len_in = 11'd5;
         end else begin
            start = 1'b0;
         end
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
         end
         if (k == 0) busy_k0 = int'(o_busy);
         if (o_en) begin
            if (first_en < 0) first_en = k;
            last_en = k;
            en_cnt++;
            if (n_nib < 4096) begin
               nib[n_nib] = int'(o_txd);
               n_nib++;
            end
         end
         if (o_rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = k;
         end
         if (o_er) begin
            er_cnt++;
            if (first_er < 0) first_er = k;
         end
         if (o_urun) begin
            urun_cnt++;
            urun_at = k;
         end
         if (rst_at >= 0 && k == rst_at + 1) begin
            post_en   = int'(o_en);
            post_busy = int'(o_busy);
            post_txd  = int'(o_txd);
            post_er   = int'(o_er);
            rst = 1'b0;
            break;
         end
         if (o_done) begin
            done_at = k;
            break;
         end
      end
      start = 1'b0;
      if (rst_at < 0) check_val("done_seen", int'(done_at >= 0), 1);
      $display("frame len=%0d dut=%0d en=%0d rd=%0d er=%0d done_at=%0d",
               len, sel, en_cnt, rd_cnt, er_cnt, done_at);
   endtask

   task automatic check_frame(input string tag, input int len, input int minf);
      int          plen, bad;
      logic [31:0] fcs;
      plen = (len > minf) ? len : minf;
      check_val({tag, "_idle_before"}, idle_before, 0);
      check_val({tag, "_busy_k0"}, busy_k0, 1);
      check_val({tag, "_first_en"}, first_en, 0);
      check_val({tag, "_en_cnt"}, en_cnt, 16 + 2 * plen + 8);
      bad = 0;
      for (int i = 0; i < 14; i++) if (nib[i] != 5) bad++;
      if (nib[14] != 5 || nib[15] != 13) bad++;
      check_val({tag, "_preamble_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < len; i++) begin
         if (nib[16 + 2 * i] != int'(mem[i[10:0]] & 8'h0F)) bad++;
         if (nib[17 + 2 * i] != int'(mem[i[10:0]] >> 4)) bad++;
      end
      check_val({tag, "_payload_bad"}, bad, 0);
      bad = 0;
      for (int i = 2 * len; i < 2 * plen; i++) if (nib[16 + i] != 0) bad++;
      check_val({tag, "_pad_bad"}, bad, 0);
      fcs = ~ref_crc(len, minf);
      bad = 0;
      for (int j = 0; j < 8; j++) begin
         logic [31:0] s;
         s = fcs >> (4 * j);
         if (nib[16 + 2 * plen + j] != int'(s[3:0])) bad++;
      end
      check_val({tag, "_fcs_bad"}, bad, 0);
      check_val({tag, "_rd_cnt"}, rd_cnt, len);
      check_val({tag, "_first_rd"}, first_rd, 14);
      check_val({tag, "_er_cnt"}, er_cnt, 0);
      check_val({tag, "_urun_cnt"}, urun_cnt, 0);
      check_val({tag, "_done_gap"}, done_at - last_en, 24);
   endtask

   int fcs_ref [0:7] = '{6, 2, 9, 3, 4, 15, 11, 12};

   initial begin
      rst = 1'b1; start = 1'b0; len_in = 11'd0; sel = 1'b1;
      fifo_clr = 1'b0; wr_n = 11'd0; rd_n = 11'd0;
      dout_a = 8'h00; dout_b = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset state of both instances.
      check_val("rst_busy", int'(busy_b | busy_a), 0);
      check_val("rst_en", int'(en_b | en_a), 0);
      check_val("rst_txd", int'(txd_b | txd_a), 0);
      check_val("rst_er_done_urun", int'(er_b | done_b | urun_b | er_a | done_a | urun_a), 0);
      check_val("rst_rd", int'(rd_b | rd_a), 0);
      rst = 1'b0;

      // "123456789" with no padding: known CRC 0xCBF43926.
      sel = 1'b0;
      fifo_reset();
      for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
      wr_n = 11'd9;
      run_frame(11'd9, -1, -1, 200);
      check_frame("t1", 9, 0);
      for (int j = 0; j < 8; j++) check_val($sformatf("t1_fcs_nib%0d", j), nib[34 + j], fcs_ref[j]);

      // Single byte padded to 60.
      sel = 1'b1;
      fifo_reset();
      mem[0] = 8'hA5;
      wr_n = 11'd1;
      run_frame(11'd1, -1, -1, 400);
      check_frame("t2", 1, 60);
      check_val("t2_nib16", nib[16], 5);
      check_val("t2_nib17", nib[17], 10);

      // Maximum length.
      fifo_reset();
      for (int i = 0; i < 1514; i++) mem[i] = 8'(i * 7 + 3);
      wr_n = 11'd1514;
      run_frame(11'd1514, -1, -1, 3300);
      check_frame("t3", 1514, 60);

      // Underrun at payload byte 3.
      fifo_reset();
      for (int i = 0; i < 3; i++) mem[i] = 8'h10 + 8'(i);
      wr_n = 11'd3;
      run_frame(11'd10, -1, -1, 300);
      check_val("t4_er_cnt", er_cnt, 2);
      check_val("t4_first_er", first_er, 22);
      check_val("t4_urun_at", urun_at, 22);
      check_val("t4_urun_cnt", urun_cnt, 1);
      check_val("t4_rd_cnt", rd_cnt, 3);
      check_val("t4_en_cnt", en_cnt, 24);
      check_val("t4_abort_txd", nib[22] + nib[23], 0);
      check_val("t4_done_gap", done_at - last_en, 24);

      // tx_len=0 request is ignored.
      @(negedge clk);
      start = 1'b1; len_in = 11'd0;
      @(negedge clk);
      start = 1'b0;
      check_val("t5_len0_busy", int'(o_busy), 0);
      check_val("t5_len0_en", int'(o_en), 0);

      // tx_start during busy (with tx_len changed) is ignored.
      fifo_reset();
      mem[0] = 8'h3C; mem[1] = 8'hE7;
      wr_n = 11'd2;
      run_frame(11'd2, 40, -1, 400);
      check_frame("t5_busy", 2, 60);

      // Back-to-back: request in the cycle right after tx_done.
      fifo_reset();
      wr_n = 11'd2;
      run_frame(11'd2, -1, -1, 400);
      check_frame("t5_b2b", 2, 60);

      // Reset at c=30 (a prefetch cycle) mid-frame.
      fifo_reset();
      for (int i = 0; i < 20; i++) mem[i] = 8'h80 + 8'(i);
      wr_n = 11'd20;
      run_frame(11'd20, -1, 30, 200);
      check_val("t6_rd_before_rst", rd_cnt, 8);
      check_val("t6_post_en", post_en, 0);
      check_val("t6_post_busy", post_busy, 0);
      check_val("t6_post_txd", post_txd, 0);
      check_val("t6_post_er", post_er, 0);
      begin
         int rd_after;
         rd_after = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_rd) rd_after++;
         end
         check_val("t6_rd_after_rst", rd_after, 0);
      end
      fifo_reset();
      for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
      wr_n = 11'd9;
      run_frame(11'd9, -1, -1, 400);
      check_frame("t6_after", 9, 60);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
